// File: rtl/mem_stream_reader.sv
// Burst reader for a one-cycle-latency memory: issues num_reads_i sequential reads
// from base_addr_i and returns the words as a valid/ready stream through a 2-entry buffer.
module mem_stream_reader #(
  parameter int DATA_WIDTH      = 8,
  parameter int LOG_MAX_ADDRESS = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [LOG_MAX_ADDRESS-1:0] base_addr_i,
  input  logic [LOG_MAX_ADDRESS:0]   num_reads_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [LOG_MAX_ADDRESS-1:0] addr_read_o,
  output logic                       read_o,
  input  logic [DATA_WIDTH-1:0]      data_read_i,
  input  logic                       valid_read_i,
  output logic [DATA_WIDTH-1:0]      data_out_o,
  output logic                       valid_out_o,
  input  logic                       ready_in_i
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [LOG_MAX_ADDRESS-1:0] ADDR_ONE = 1;
  localparam logic [LOG_MAX_ADDRESS:0]   REM_ONE  = 1;

  state_e                        state_q, state_d;
  logic [LOG_MAX_ADDRESS-1:0]    addr_q, addr_d;
  logic [LOG_MAX_ADDRESS:0]      rem_q, rem_d;
  logic [1:0]                    count_q, count_d;
  logic [1:0][DATA_WIDTH-1:0]    buf_q;
  logic                          wr_ptr_q, rd_ptr_q;
  logic                          inflight_q;
  logic                          push, pop, rd;
  logic [2:0]                    level;

  // level is the occupancy after this cycle's push/pop; a read issued now lands next cycle
  always_comb begin
    pop   = (count_q != 2'd0) & ready_in_i;
    push  = valid_read_i & ((state_q == S_RUN) | (state_q == S_DRAIN));
    level = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
    count_d = level[1:0];
    rd    = (state_q == S_RUN) & (rem_q != '0) & (level < 3'd2);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = num_reads_i;
          state_d = (num_reads_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rd) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - REM_ONE;
          if (rem_q == REM_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave only once the word being popped now is the last one anywhere
        if ((count_d == 2'd0) && !valid_read_i && !inflight_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      buf_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      inflight_q <= rd;
      if (push) buf_q[wr_ptr_q] <= data_read_i;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
    end
  end

  assign busy_o      = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign addr_read_o = addr_q;
  assign read_o      = rd;
  assign valid_out_o = (count_q != 2'd0);
  assign data_out_o  = buf_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: memory model with mem[a]=a+1, queue-based stream model
// checked every cycle, plus literal cycle-accurate expectations for each directed burst.
module tb_mem_stream_reader;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_reads = '0;
  logic          busy, done, read, valid_out;
  logic [AW-1:0] addr_read;
  logic [DW-1:0] data_read = '0;
  logic          valid_read = 1'b0;
  logic [DW-1:0] data_out;
  logic          ready_in = 1'b0;

  always #5 clk = ~clk;

  mem_stream_reader #(.DATA_WIDTH(DW), .LOG_MAX_ADDRESS(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
    .num_reads_i(num_reads), .busy_o(busy), .done_o(done), .addr_read_o(addr_read),
    .read_o(read), .data_read_i(data_read), .valid_read_i(valid_read),
    .data_out_o(data_out), .valid_out_o(valid_out), .ready_in_i(ready_in)
  );

  // Registered-output memory, contents mem[a] = (a+1) mod 256
  always @(posedge clk) begin
    valid_read <= read;
    if (read) data_read <= addr_read[7:0] + 8'd1;
  end

  int chk = 0;
  int err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream model: the words and addresses a burst must produce, in order
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            outstanding = 0;
  bit            expect_done = 0;
  int            done_seen = 0;
  logic          prev_vout = 0, prev_rdy = 0, prev_read = 0;
  logic [DW-1:0] prev_data = '0;

  logic          tr_read[64], tr_busy[64], tr_done[64], tr_vout[64];
  logic [AW-1:0] tr_addr[64];
  logic [DW-1:0] tr_data[64];
  bit            tracing = 0;
  int            s0 = 0;
  int            k;

  always begin
    @(negedge clk); #2;
    if (!rst_n) begin
      exp_addr.delete(); exp_data.delete();
      outstanding = 0; expect_done = 0;
      prev_vout = 0; prev_rdy = 0; prev_read = 0; prev_data = '0;
    end else begin
      if (tracing) begin
        k = cyc - s0 + 1;
        if (k >= 1 && k < 64) begin
          tr_read[k] = read; tr_busy[k] = busy; tr_done[k] = done;
          tr_vout[k] = valid_out; tr_addr[k] = addr_read; tr_data[k] = data_out;
        end
      end
      if (valid_read) check("valid_read_without_read", prev_read, 1);
      if (prev_vout && !prev_rdy) begin
        check("hold_valid", valid_out, 1);
        check("hold_data", data_out, prev_data);
      end
      if (read) begin
        if (exp_addr.size() == 0) check("extra_read", read, 0);
        else begin
          check("read_addr", addr_read, exp_addr.pop_front());
          outstanding++;
        end
      end
      if (valid_out && ready_in) begin
        if (exp_data.size() == 0) check("extra_word", valid_out, 0);
        else begin
          check("word", data_out, exp_data.pop_front());
          outstanding--;
        end
      end
      if (busy) check("occupancy_le_2", outstanding <= 2, 1);
      if (done) begin
        check("done_expected", expect_done, 1);
        if (expect_done) check("done_all_consumed", exp_data.size() + exp_addr.size(), 0);
        expect_done = 0;
        done_seen++;
      end
      prev_vout = valid_out; prev_rdy = ready_in; prev_data = data_out; prev_read = read;
    end
  end

  // One burst: start at edge 0, then ncyc cycles; pat gives ready_in for cycles 1..plen
  task automatic burst(input logic [AW-1:0] base, input logic [AW:0] n, input int ncyc,
                       input logic [15:0] pat, input int plen, input int rst_at, input int dbl_at);
    logic [AW-1:0] a;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      tr_read[i] = 0; tr_busy[i] = 0; tr_done[i] = 0; tr_vout[i] = 0;
      tr_addr[i] = '0; tr_data[i] = '0;
    end
    for (int i = 0; i < int'(n); i++) begin
      a = base + AW'(i);
      exp_addr.push_back(a);
      exp_data.push_back(DW'(a + 16'd1));
    end
    expect_done = 1;
    start = 1; base_addr = base; num_reads = n; ready_in = 1'b1;
    @(posedge clk); #1;
    s0 = cyc; tracing = 1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 0;
      ready_in = (c <= plen) ? pat[c-1] : 1'b1;
      if (c == dbl_at) begin start = 1; base_addr = 16'h0080; num_reads = 17'd5; end
      if (c == rst_at) begin
        rst_n = 0; #1;
        check("rst_busy", busy, 0);      check("rst_done", done, 0);
        check("rst_read", read, 0);      check("rst_addr", addr_read, 0);
        check("rst_valid_out", valid_out, 0); check("rst_data_out", data_out, 0);
      end
    end
    #3;
    tracing = 0;
  endtask

  logic [AW-1:0] wa[4];
  logic [DW-1:0] wd[4];
  int            dseen;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", busy, 0);       check("reset_done", done, 0);
    check("reset_read", read, 0);       check("reset_addr", addr_read, 0);
    check("reset_valid_out", valid_out, 0); check("reset_data_out", data_out, 0);
    @(negedge clk); rst_n = 1;

    // Basic burst, ready held high
    burst(16'h0010, 17'd4, 9, 16'h0000, 0, 0, 0);
    for (int c = 1; c <= 4; c++) check("basic_read", {tr_read[c], tr_addr[c]}, {1'b1, 16'h000F + 16'(c)});
    check("basic_read_c5", tr_read[5], 0);
    check("basic_vout_c2", tr_vout[2], 0);
    for (int c = 3; c <= 6; c++) check("basic_data", {tr_vout[c], tr_data[c]}, {1'b1, 8'h0E + 8'(c)});
    check("basic_done_c6", tr_done[6], 0);
    check("basic_done_c7", tr_done[7], 1);
    check("basic_busy_c1", tr_busy[1], 1);
    check("basic_busy_c6", tr_busy[6], 1);
    check("basic_busy_c7", tr_busy[7], 0);
    check("basic_done_seen", expect_done, 0);

    // Backpressure: ready 1,0,0,1,0,1,0,1 then 1
    burst(16'h0010, 17'd4, 12, 16'h00A9, 8, 0, 0);
    check("bp_read_c3", tr_read[3], 0);
    check("bp_read_c4", {tr_read[4], tr_addr[4]}, {1'b1, 16'h0012});
    check("bp_read_c5", tr_read[5], 0);
    check("bp_read_c6", {tr_read[6], tr_addr[6]}, {1'b1, 16'h0013});
    check("bp_data_c9", {tr_vout[9], tr_data[9]}, {1'b1, 8'h14});
    check("bp_done_c9", tr_done[9], 0);
    check("bp_done_c10", tr_done[10], 1);
    check("bp_done_seen", expect_done, 0);

    // Zero length
    burst(16'h0055, 17'd0, 4, 16'h0000, 0, 0, 0);
    check("zero_done_c1", tr_done[1], 1);
    check("zero_done_c2", tr_done[2], 0);
    for (int c = 1; c <= 4; c++) check("zero_quiet", {tr_read[c], tr_vout[c], tr_busy[c]}, 0);

    // Address wrap
    burst(16'hFFFE, 17'd4, 9, 16'h0000, 0, 0, 0);
    wa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    wd = '{8'hFF, 8'h00, 8'h01, 8'h02};
    for (int c = 1; c <= 4; c++) check("wrap_addr", {tr_read[c], tr_addr[c]}, {1'b1, wa[c-1]});
    for (int c = 3; c <= 6; c++) check("wrap_data", {tr_vout[c], tr_data[c]}, {1'b1, wd[c-3]});
    check("wrap_done_c7", tr_done[7], 1);

    // Second start while busy must be ignored
    burst(16'h0040, 17'd3, 10, 16'h0000, 0, 0, 2);
    check("dbl_done_c6", tr_done[6], 1);
    for (int c = 7; c <= 10; c++) check("dbl_no_read", {tr_read[c], tr_busy[c]}, 0);
    check("dbl_done_seen", expect_done, 0);

    // Reset mid-burst with ready low, then a clean burst
    dseen = done_seen;
    burst(16'h0020, 17'd8, 6, 16'h0000, 6, 4, 0);
    @(negedge clk); rst_n = 1;
    repeat (4) @(negedge clk);
    check("rst_no_done", done_seen, dseen);
    burst(16'h0030, 17'd8, 13, 16'h0000, 0, 0, 0);
    for (int c = 3; c <= 10; c++) check("post_rst_data", {tr_vout[c], tr_data[c]}, {1'b1, 8'h2E + 8'(c)});
    check("post_rst_done_c11", tr_done[11], 1);
    check("post_rst_done_seen", expect_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
